// File: rtl/otter_lsu.sv
// Load/store unit between the OTTER pipeline and its data memory port: size/sign handling,
// IO passthrough and, when LSU_MISALIGN_EN is defined, splitting of word-spanning accesses.
module otter_lsu #(
    parameter logic [31:0] IO_BASE = 32'h11000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr2,
    output logic [31:0] mem_din2,
    output logic        mem_write2,
    output logic        mem_read2,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_dout2,
    output logic [2:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid & req_ready; req_ready
    // is high only while idle, and the single response is a one-cycle rsp_valid pulse.
    typedef enum logic [2:0] {IDLE, RD0, RD1, WR, RESP} state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q, wdata_q, word0, word1_v, shifted, load_data;
    logic [63:0] pair;
    logic [1:0]  size_q;
    logic        sign_q, we_q, err_q;
    logic        accept, req_io, req_span, req_err, q_io;

    function automatic logic spans(input logic [1:0] off, input logic [1:0] size);
        case (size)
            2'd1:    spans = (off == 2'd3);
            2'd2:    spans = (off != 2'd0);
            default: spans = 1'b0;
        endcase
    endfunction

    assign accept    = req_valid && req_ready;
    assign req_io    = req_addr >= IO_BASE;
    assign req_span  = spans(req_addr[1:0], req_size) && !req_io;
    assign q_io      = addr_q >= IO_BASE;
    assign dbg_state = state;

`ifdef LSU_MISALIGN_EN
    logic [31:0] word1;
    logic [1:0]  cnt, last_beat;
    logic        q_span;
    assign q_span    = spans(addr_q[1:0], size_q) && !q_io;
    assign last_beat = (size_q == 2'd1) ? 2'd1 : 2'd3;
    assign word1_v   = word1;
    assign req_err   = (req_size == 2'd3);
`else
    assign word1_v   = 32'd0;
    assign req_err   = (req_size == 2'd3) || req_span;
`endif

    // Window of the two fetched words starting at the requested byte.
    assign pair    = {word1_v, word0};
    assign shifted = pair[{1'b0, addr_q[1:0], 3'b000} +: 32];

    always_comb begin
        load_data = shifted;
        if (q_io) begin
            load_data = word0;
        end else begin
            case (size_q)
                2'd0: load_data = sign_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                2'd1: load_data = sign_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                default: load_data = shifted;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = 32'd0;
        rsp_err    = 1'b0;
        mem_read2  = 1'b0;
        mem_write2 = 1'b0;
        mem_addr2  = 32'd0;
        mem_din2   = 32'd0;
        mem_size   = 2'd0;
        mem_sign   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = req_err ? RESP : (req_we ? WR : RD0);
            end
            RD0: begin
                mem_read2 = 1'b1;
                mem_size  = 2'd2;
                mem_sign  = 1'b1;
                mem_addr2 = q_io ? addr_q : {addr_q[31:2], 2'b00};
`ifdef LSU_MISALIGN_EN
                state_nx  = q_span ? RD1 : RESP;
`else
                state_nx  = RESP;
`endif
            end
`ifdef LSU_MISALIGN_EN
            RD1: begin
                mem_read2 = 1'b1;
                mem_size  = 2'd2;
                mem_sign  = 1'b1;
                mem_addr2 = {addr_q[31:2], 2'b00} + 32'd4;
                state_nx  = RESP;
            end
`endif
            WR: begin
                mem_write2 = 1'b1;
                mem_sign   = sign_q;
                mem_size   = size_q;
                mem_addr2  = addr_q;
                mem_din2   = wdata_q;
                state_nx   = RESP;
`ifdef LSU_MISALIGN_EN
                // Spanning store: one byte beat per cycle, byte cnt of the data to addr+cnt.
                if (q_span) begin
                    mem_size  = 2'd0;
                    mem_addr2 = addr_q + {30'd0, cnt};
                    mem_din2  = {24'd0, wdata_q[{cnt, 3'b000} +: 8]};
                    state_nx  = (cnt == last_beat) ? RESP : WR;
                end
`endif
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? 32'd0 : load_data;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            word0   <= 32'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                sign_q  <= req_sign;
                we_q    <= req_we;
                err_q   <= req_err;
            end
            if (state == RD0) word0 <= mem_dout2;
        end
    end

`ifdef LSU_MISALIGN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word1 <= 32'd0;
            cnt   <= 2'd0;
        end else begin
            if (state == RD1) word1 <= mem_dout2;
            if (state == WR && q_span) cnt <= cnt + 2'd1;
            else cnt <= 2'd0;
        end
    end
`endif

endmodule

// File: tb/tb_otter_lsu.sv
// Directed bench for otter_lsu with a negedge-clocked byte memory model; covers both builds
// of LSU_MISALIGN_EN.
module tb_otter_lsu;

    localparam logic [31:0] IO_BASE = 32'h11000000;
    localparam logic [31:0] IO_RD   = 32'h13579BDF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_ready, rsp_valid, rsp_err, mem_write2, mem_read2, mem_sign;
    logic [31:0] rsp_rdata, mem_addr2, mem_din2;
    logic [31:0] mem_dout2 = 32'd0;
    logic [1:0]  mem_size;
    logic [2:0]  dbg_state;

    logic [7:0]  mem [0:4095];
    logic [31:0] wr_addr_q[$], wr_din_q[$], rd_addr_q[$];
    int          n_checks = 0, n_fail = 0;

    otter_lsu #(.IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_sign(req_sign), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr2(mem_addr2), .mem_din2(mem_din2), .mem_write2(mem_write2),
        .mem_read2(mem_read2), .mem_size(mem_size), .mem_sign(mem_sign),
        .mem_dout2(mem_dout2), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory samples strobes on the falling edge; read data is ready for the next rising edge.
    always @(negedge clk) begin
        if (mem_write2) begin
            wr_addr_q.push_back(mem_addr2);
            wr_din_q.push_back(mem_din2);
            if (mem_addr2 < IO_BASE) begin
                for (int b = 0; b < 4; b++) begin
                    if (b == 0 || (b == 1 && mem_size != 2'd0) || mem_size == 2'd2)
                        mem[mem_addr2[11:0] + 12'(b)] <= mem_din2[8*b +: 8];
                end
            end
        end
        if (mem_read2) begin
            rd_addr_q.push_back(mem_addr2);
            if (mem_addr2 >= IO_BASE) mem_dout2 <= IO_RD;
            else mem_dout2 <= {mem[{mem_addr2[11:2], 2'b11}], mem[{mem_addr2[11:2], 2'b10}],
                               mem[{mem_addr2[11:2], 2'b01}], mem[{mem_addr2[11:2], 2'b00}]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] addr, input logic [31:0] data);
        for (int b = 0; b < 4; b++) mem[addr[11:0] + 12'(b)] <= data[8*b +: 8];
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_din_q.delete();
        rd_addr_q.delete();
    endtask

    // Issue one request and check latency, data, error flag and the one-cycle pulse.
    task automatic run(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic sign,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        int   lat;
        logic seen;
        logic [31:0] rdata;
        logic err;
        @(negedge clk);
        clear_logs();
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_sign = sign;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        lat = 0; seen = 1'b0; rdata = 32'd0; err = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1; lat = i; rdata = rsp_rdata; err = rsp_err;
            end
        end
        check({tag, "_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_idle_rdata"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        int seen_rsp;
        for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_strobes", {30'd0, mem_read2, mem_write2}, 32'd0);
        check("rst_addr", mem_addr2, 32'd0);
        check("rst_din", mem_din2, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);

        set_word(32'h100, 32'hDEADBEEF);
        run("lw100", 1'b0, 32'h100, 32'd0, 2'd2, 1'b0, 2, 32'hDEADBEEF, 1'b0);
        check("lw100_rdaddr", (rd_addr_q.size() == 1) ? rd_addr_q[0] : 32'hFFFFFFFF, 32'h100);

        set_word(32'h100, 32'h80FF0000);
        run("lb103", 1'b0, 32'h103, 32'd0, 2'd0, 1'b0, 2, 32'hFFFFFF80, 1'b0);
        run("lbu103", 1'b0, 32'h103, 32'd0, 2'd0, 1'b1, 2, 32'h00000080, 1'b0);
        run("lh102", 1'b0, 32'h102, 32'd0, 2'd1, 1'b0, 2, 32'hFFFF80FF, 1'b0);
        run("lhu102", 1'b0, 32'h102, 32'd0, 2'd1, 1'b1, 2, 32'h000080FF, 1'b0);

        run("sw300", 1'b1, 32'h300, 32'h12345678, 2'd2, 1'b0, 2, 32'd0, 1'b0);
        check("sw300_beats", wr_addr_q.size(), 1);
        run("sb301", 1'b1, 32'h301, 32'h000000AB, 2'd0, 1'b0, 2, 32'd0, 1'b0);
        run("lw300a", 1'b0, 32'h300, 32'd0, 2'd2, 1'b0, 2, 32'h1234AB78, 1'b0);
        run("sh302", 1'b1, 32'h302, 32'h0000CAFE, 2'd1, 1'b0, 2, 32'd0, 1'b0);
        run("lw300b", 1'b0, 32'h300, 32'd0, 2'd2, 1'b0, 2, 32'hCAFEAB78, 1'b0);

        run("size3", 1'b0, 32'h100, 32'd0, 2'd3, 1'b0, 1, 32'd0, 1'b1);
        check("size3_noread", rd_addr_q.size(), 0);

`ifdef LSU_MISALIGN_EN
        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776655);
        run("lw102", 1'b0, 32'h102, 32'd0, 2'd2, 1'b0, 3, 32'h66554433, 1'b0);
        check("lw102_nreads", rd_addr_q.size(), 2);
        check("lw102_rd0", (rd_addr_q.size() > 0) ? rd_addr_q[0] : 32'hFFFFFFFF, 32'h100);
        check("lw102_rd1", (rd_addr_q.size() > 1) ? rd_addr_q[1] : 32'hFFFFFFFF, 32'h104);

        set_word(32'h200, 32'd0);
        set_word(32'h204, 32'd0);
        run("sw201", 1'b1, 32'h201, 32'hAABBCCDD, 2'd2, 1'b0, 5, 32'd0, 1'b0);
        check("sw201_beats", wr_addr_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_bytes;
            exp_bytes = 32'hAABBCCDD;
            check($sformatf("sw201_addr%0d", k),
                  (wr_addr_q.size() > k) ? wr_addr_q[k] : 32'hFFFFFFFF, 32'h201 + k);
            check($sformatf("sw201_din%0d", k),
                  (wr_din_q.size() > k) ? {24'd0, wr_din_q[k][7:0]} : 32'hFFFFFFFF,
                  {24'd0, exp_bytes[8*k +: 8]});
        end
        run("lw200", 1'b0, 32'h200, 32'd0, 2'd2, 1'b0, 2, 32'hBBCCDD00, 1'b0);
        run("lw204", 1'b0, 32'h204, 32'd0, 2'd2, 1'b0, 2, 32'h000000AA, 1'b0);
        run("sh203", 1'b1, 32'h203, 32'h00001234, 2'd1, 1'b0, 3, 32'd0, 1'b0);
        check("sh203_beats", wr_addr_q.size(), 2);
`else
        run("sh203", 1'b1, 32'h203, 32'h00001234, 2'd1, 1'b0, 1, 32'd0, 1'b1);
        check("sh203_nowrite", wr_addr_q.size(), 0);
        run("lw102", 1'b0, 32'h102, 32'd0, 2'd2, 1'b0, 1, 32'd0, 1'b1);
        check("lw102_noread", rd_addr_q.size(), 0);
`endif

        run("io_sw", 1'b1, 32'h11000004, 32'h5, 2'd2, 1'b0, 2, 32'd0, 1'b0);
        check("io_sw_beats", wr_addr_q.size(), 1);
        check("io_sw_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hFFFFFFFF, 32'h11000004);
        check("io_sw_din", (wr_din_q.size() > 0) ? wr_din_q[0] : 32'hFFFFFFFF, 32'h5);
        run("io_lw", 1'b0, 32'h11000002, 32'd0, 2'd2, 1'b0, 2, IO_RD, 1'b0);
        check("io_lw_addr", (rd_addr_q.size() > 0) ? rd_addr_q[0] : 32'hFFFFFFFF, 32'h11000002);

        // Reset in the middle of a load: the request must vanish without a response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sign = 1'b0;
`ifdef LSU_MISALIGN_EN
        req_addr = 32'h102;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check("midrst_in_rd1", {29'd0, dbg_state}, 32'd2);
`else
        req_addr = 32'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("midrst_in_rd0", {29'd0, dbg_state}, 32'd1);
`endif
        #2 rst_n = 1'b0;
        #1 check("midrst_state", {29'd0, dbg_state}, 32'd0);
        check("midrst_strobes", {30'd0, mem_read2, mem_write2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_rsp = 0;
        @(negedge clk);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen_rsp++;
            @(negedge clk);
        end
        check("midrst_no_rsp", seen_rsp, 0);

        run("post_rst_lw", 1'b0, 32'h300, 32'd0, 2'd2, 1'b0, 2, 32'hCAFEAB78, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
